// File: rtl/nanocore_peri_pkg.sv
// nanocore_peri_pkg
// Shared types and constants for the peripheral bus arbiter.
//   peri_arb_state_e : arbiter FSM states
//   peri_op_e        : latched transaction direction
//   peri_req_t       : latched downstream request payload
//   ERR_RDATA        : read data returned on a timed-out transaction
package nanocore_peri_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        ISSUE     = 2'd1,
        WAIT_RESP = 2'd2
    } peri_arb_state_e;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } peri_op_e;

    localparam logic [31:0] ERR_RDATA = 32'hDEAD_BEEF;

    typedef struct packed {
        peri_op_e    op;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } peri_req_t;

endpackage

// File: rtl/peri_bus_arbiter_rr.sv
// rr_arbiter
// Combinational round-robin pick among N requesters.
//   req   in  N      request vector
//   ptr   in  IDX_W  index with highest priority this round
//   gnt   out N      one-hot grant (0 when no request)
//   idx   out IDX_W  index of the granted requester (0 when no request)
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] ptr,
    output logic [N-1:0]     gnt,
    output logic [IDX_W-1:0] idx
);

    logic found;

    // First pass only looks at requesters at or above ptr; the second pass
    // wraps around to the lowest index if the first pass found nothing.
    always_comb begin
        gnt   = '0;
        idx   = '0;
        found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!found && req[i] && (i >= int'(ptr))) begin
                found  = 1'b1;
                idx    = IDX_W'(i);
                gnt[i] = 1'b1;
            end
        end
        for (int i = 0; i < N; i++) begin
            if (!found && req[i]) begin
                found  = 1'b1;
                idx    = IDX_W'(i);
                gnt[i] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/peri_bus_arbiter.sv
// peri_bus_arbiter
// Shares one peripheral port among NUM_PE cores: round-robin grant, one
// outstanding transaction, response routed back to its owner, and a
// timeout so a silent peripheral cannot lock the bus.
//   i_clk, i_rst_n            clock, async active-low reset
//   i_req_rden/wren           per-core request (write wins if both set)
//   i_req_addr/wdata/wstrb    per-core payload, packed per core
//   o_req_gnt                 one-hot, combinational, same cycle as request
//   o_resp_ready/err          one-hot registered response pulse
//   o_resp_rdata              response data, held until next response
//   o_peri_*                  downstream request and payload
//   i_peri_rdata/ready/gnt    downstream response and acceptance
//
// state     | meaning
// IDLE      | no transaction; pick and grant a requester
// ISSUE     | request driven downstream until i_peri_gnt
// WAIT_RESP | accepted downstream, waiting for i_peri_ready or timeout
module peri_bus_arbiter
    import nanocore_peri_pkg::*;
#(
    parameter int NUM_PE  = 4,
    parameter int TIMEOUT = 1024
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [NUM_PE-1:0]     i_req_rden,
    input  logic [NUM_PE-1:0]     i_req_wren,
    input  logic [NUM_PE*32-1:0]  i_req_addr,
    input  logic [NUM_PE*32-1:0]  i_req_wdata,
    input  logic [NUM_PE*4-1:0]   i_req_wstrb,
    output logic [NUM_PE-1:0]     o_req_gnt,
    output logic [NUM_PE-1:0]     o_resp_ready,
    output logic [NUM_PE-1:0]     o_resp_err,
    output logic [31:0]           o_resp_rdata,
    output logic                  o_peri_rden,
    output logic                  o_peri_wren,
    output logic [31:0]           o_peri_addr,
    output logic [31:0]           o_peri_wdata,
    output logic [3:0]            o_peri_wstrb,
    input  logic [31:0]           i_peri_rdata,
    input  logic                  i_peri_ready,
    input  logic                  i_peri_gnt
);

    localparam int IDX_W = (NUM_PE > 1) ? $clog2(NUM_PE) : 1;
    localparam int CNT_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
    localparam bit TO_EN = (TIMEOUT != 0);
    localparam logic [CNT_W-1:0] CNT_MAX  = (TIMEOUT > 0) ? CNT_W'(TIMEOUT) : '1;
    // Timeout fires in the cycle the counter would step onto TIMEOUT.
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;

    peri_arb_state_e   state_q, state_d;
    logic [IDX_W-1:0]  rr_ptr_q;
    logic [IDX_W-1:0]  owner_q;
    peri_req_t         req_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [NUM_PE-1:0] resp_ready_q;
    logic [NUM_PE-1:0] resp_err_q;
    logic [31:0]       resp_rdata_q;

    logic [NUM_PE-1:0] req_vec;
    logic [NUM_PE-1:0] arb_gnt;
    logic [IDX_W-1:0]  arb_idx;

    logic grant_take;
    logic cnt_clr;
    logic cnt_inc;
    logic done;
    logic done_err;

    assign req_vec = i_req_rden | i_req_wren;

    rr_arbiter #(
        .N     (NUM_PE),
        .IDX_W (IDX_W)
    ) u_rr_arbiter (
        .req (req_vec),
        .ptr (rr_ptr_q),
        .gnt (arb_gnt),
        .idx (arb_idx)
    );

    always_comb begin
        state_d     = state_q;
        grant_take  = 1'b0;
        cnt_clr     = 1'b0;
        cnt_inc     = 1'b0;
        done        = 1'b0;
        done_err    = 1'b0;
        o_req_gnt   = '0;
        o_peri_rden = 1'b0;
        o_peri_wren = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req_vec) begin
                    o_req_gnt  = arb_gnt;
                    grant_take = 1'b1;
                    state_d    = ISSUE;
                end
            end
            ISSUE: begin
                o_peri_rden = (req_q.op == OP_READ);
                o_peri_wren = (req_q.op == OP_WRITE);
                if (i_peri_gnt) begin
                    if (i_peri_ready) begin
                        done    = 1'b1;
                        state_d = IDLE;
                    end else begin
                        cnt_clr = 1'b1;
                        state_d = WAIT_RESP;
                    end
                end
            end
            WAIT_RESP: begin
                if (i_peri_ready) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end else begin
                    cnt_inc = 1'b1;
                    if (TO_EN && (cnt_q == CNT_LAST)) begin
                        done     = 1'b1;
                        done_err = 1'b1;
                        state_d  = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q      <= IDLE;
            rr_ptr_q     <= '0;
            owner_q      <= '0;
            req_q        <= '0;
            cnt_q        <= '0;
            resp_ready_q <= '0;
            resp_err_q   <= '0;
            resp_rdata_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_take) begin
                owner_q     <= arb_idx;
                rr_ptr_q    <= (arb_idx == IDX_W'(NUM_PE - 1)) ? '0 : arb_idx + IDX_W'(1);
                req_q.op    <= i_req_wren[arb_idx] ? OP_WRITE : OP_READ;
                req_q.addr  <= i_req_addr[int'(arb_idx)*32 +: 32];
                req_q.wdata <= i_req_wdata[int'(arb_idx)*32 +: 32];
                req_q.wstrb <= i_req_wstrb[int'(arb_idx)*4 +: 4];
            end

            if (cnt_clr) begin
                cnt_q <= '0;
            end else if (cnt_inc && (cnt_q != CNT_MAX)) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            resp_ready_q <= '0;
            resp_err_q   <= '0;
            if (done) begin
                resp_ready_q[owner_q] <= 1'b1;
                resp_err_q[owner_q]   <= done_err;
                if (done_err) begin
                    resp_rdata_q <= ERR_RDATA;
                end else if (req_q.op == OP_WRITE) begin
                    resp_rdata_q <= '0;
                end else begin
                    resp_rdata_q <= i_peri_rdata;
                end
            end
        end
    end

    assign o_resp_ready = resp_ready_q;
    assign o_resp_err   = resp_err_q;
    assign o_resp_rdata = resp_rdata_q;
    assign o_peri_addr  = req_q.addr;
    assign o_peri_wdata = req_q.wdata;
    assign o_peri_wstrb = (req_q.op == OP_WRITE) ? req_q.wstrb : 4'b0000;

endmodule

// File: tb/tb_peri_bus_arbiter.sv
// tb_peri_bus_arbiter
// Directed scenarios with literal expectations, plus a transaction-level
// model of the arbiter checked against every output on every falling edge.
module tb_peri_bus_arbiter;

    localparam int NPE = 4;
    localparam int TMO = 8;

    logic              clk;
    logic              rst_n;
    logic [NPE-1:0]    req_rden;
    logic [NPE-1:0]    req_wren;
    logic [NPE*32-1:0] req_addr;
    logic [NPE*32-1:0] req_wdata;
    logic [NPE*4-1:0]  req_wstrb;
    logic [NPE-1:0]    req_gnt;
    logic [NPE-1:0]    resp_ready;
    logic [NPE-1:0]    resp_err;
    logic [31:0]       resp_rdata;
    logic              peri_rden;
    logic              peri_wren;
    logic [31:0]       peri_addr;
    logic [31:0]       peri_wdata;
    logic [3:0]        peri_wstrb;
    logic [31:0]       peri_rdata;
    logic              peri_ready;
    logic              peri_gnt;

    int n_cmp = 0;
    int n_bad = 0;

    peri_bus_arbiter #(
        .NUM_PE  (NPE),
        .TIMEOUT (TMO)
    ) dut (
        .i_clk        (clk),
        .i_rst_n      (rst_n),
        .i_req_rden   (req_rden),
        .i_req_wren   (req_wren),
        .i_req_addr   (req_addr),
        .i_req_wdata  (req_wdata),
        .i_req_wstrb  (req_wstrb),
        .o_req_gnt    (req_gnt),
        .o_resp_ready (resp_ready),
        .o_resp_err   (resp_err),
        .o_resp_rdata (resp_rdata),
        .o_peri_rden  (peri_rden),
        .o_peri_wren  (peri_wren),
        .o_peri_addr  (peri_addr),
        .o_peri_wdata (peri_wdata),
        .o_peri_wstrb (peri_wstrb),
        .i_peri_rdata (peri_rdata),
        .i_peri_ready (peri_ready),
        .i_peri_gnt   (peri_gnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- transaction-level model ----------------
    // busy/accepted describe where the single outstanding transaction is;
    // waited counts cycles since downstream acceptance.
    bit          m_busy, m_acc, m_wr;
    int          m_owner, m_wait, m_ptr;
    logic [31:0] m_addr, m_wdata;
    logic [3:0]  m_wstrb;
    logic [3:0]  e_ready, e_err, n_ready, n_err;
    logic [31:0] e_rdata;

    function automatic int pick_winner();
        for (int k = 0; k < NPE; k++) begin
            int c;
            c = (m_ptr + k) % NPE;
            if (req_rden[c] || req_wren[c]) return c;
        end
        return -1;
    endfunction

    function automatic void model_reset();
        m_busy = 0; m_acc = 0; m_wr = 0; m_owner = 0; m_wait = 0; m_ptr = 0;
        m_addr = '0; m_wdata = '0; m_wstrb = '0;
        e_ready = '0; e_err = '0; e_rdata = '0;
    endfunction

    function automatic void complete(input bit err);
        m_busy = 0;
        n_ready[m_owner] = 1'b1;
        n_err[m_owner]   = err;
        e_rdata = err ? 32'hDEAD_BEEF : (m_wr ? 32'h0 : peri_rdata);
    endfunction

    always @(negedge clk) begin
        int w;
        logic [3:0] eg;
        if (!rst_n) model_reset();
        w  = m_busy ? -1 : pick_winner();
        eg = '0;
        if (w >= 0) eg[w] = 1'b1;
        check("m_req_gnt",    32'(req_gnt),    32'(eg));
        check("m_peri_rden",  32'(peri_rden),  32'(m_busy && !m_acc && !m_wr));
        check("m_peri_wren",  32'(peri_wren),  32'(m_busy && !m_acc && m_wr));
        check("m_peri_addr",  peri_addr,       m_addr);
        check("m_peri_wdata", peri_wdata,      m_wdata);
        check("m_peri_wstrb", 32'(peri_wstrb), 32'(m_wr ? m_wstrb : 4'b0000));
        check("m_resp_ready", 32'(resp_ready), 32'(e_ready));
        check("m_resp_err",   32'(resp_err),   32'(e_err));
        check("m_resp_rdata", resp_rdata,      e_rdata);
        if (rst_n) begin
            n_ready = '0;
            n_err   = '0;
            if (!m_busy) begin
                if (w >= 0) begin
                    m_busy  = 1; m_acc = 0; m_owner = w;
                    m_wr    = req_wren[w];
                    m_addr  = req_addr[w*32 +: 32];
                    m_wdata = req_wdata[w*32 +: 32];
                    m_wstrb = req_wstrb[w*4 +: 4];
                    m_ptr   = (w + 1) % NPE;
                end
            end else if (!m_acc) begin
                if (peri_gnt) begin
                    if (peri_ready) complete(0);
                    else begin m_acc = 1; m_wait = 0; end
                end
            end else begin
                if (peri_ready) complete(0);
                else begin
                    m_wait++;
                    if (m_wait == TMO) complete(1);
                end
            end
            e_ready = n_ready;
            e_err   = n_err;
        end
    end

    // ---------------- directed stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int k, input bit rd, input bit wr, input logic [31:0] a,
                           input logic [31:0] d, input logic [3:0] s);
        req_rden[k] = rd;
        req_wren[k] = wr;
        req_addr[k*32 +: 32]  = a;
        req_wdata[k*32 +: 32] = d;
        req_wstrb[k*4 +: 4]   = s;
    endtask

    task automatic clear_reqs();
        req_rden = '0;
        req_wren = '0;
    endtask

    logic [3:0] rr_exp [10];

    initial begin
        rr_exp = '{4'b0001, 4'b0000, 4'b0010, 4'b0000, 4'b0100,
                   4'b0000, 4'b1000, 4'b0000, 4'b0001, 4'b0000};
        rst_n = 1'b0;
        req_rden = '0; req_wren = '0; req_addr = '0; req_wdata = '0; req_wstrb = '0;
        peri_rdata = '0; peri_ready = 1'b0; peri_gnt = 1'b0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst_resp_ready", 32'(resp_ready), 32'h0);
        check("rst_peri_rden",  32'(peri_rden),  32'h0);
        check("rst_peri_addr",  peri_addr,       32'h0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        step();
        rst_n = 1'b1;

        // Round-robin: everyone requesting, downstream answers immediately.
        step();
        for (int k = 0; k < NPE; k++) set_req(k, 1'b1, 1'b0, 32'h4000_0000 + 32'(k*16), 32'h0, 4'h0);
        peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = 32'hA5A5_0001;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            check($sformatf("rr_gnt_%0d", i), 32'(req_gnt), 32'(rr_exp[i]));
            step();
        end
        clear_reqs();
        peri_gnt = 1'b0; peri_ready = 1'b0;
        repeat (2) step();

        // Single read from core 2, gnt in cycle 2, ready in cycle 4.
        set_req(2, 1'b1, 1'b0, 32'h1000_0004, 32'h0, 4'h0);
        @(negedge clk);
        check("rd_gnt", 32'(req_gnt), 32'h4);
        step(); clear_reqs();
        @(negedge clk);
        check("rd_peri_rden", 32'(peri_rden), 32'h1);
        check("rd_peri_addr", peri_addr, 32'h1000_0004);
        step(); peri_gnt = 1'b1;
        step(); peri_gnt = 1'b0;
        step(); peri_ready = 1'b1; peri_rdata = 32'h1234_5678;
        step(); peri_ready = 1'b0; peri_rdata = 32'h0;
        @(negedge clk);
        check("rd_resp_ready", 32'(resp_ready), 32'h4);
        check("rd_resp_rdata", resp_rdata, 32'h1234_5678);
        repeat (2) step();

        // Write from core 1 with both enables set.
        set_req(1, 1'b1, 1'b1, 32'h2000_0010, 32'hCAFE_F00D, 4'b0011);
        @(negedge clk);
        check("wr_gnt", 32'(req_gnt), 32'h2);
        step(); clear_reqs();
        @(negedge clk);
        check("wr_peri_wren",  32'(peri_wren),  32'h1);
        check("wr_peri_rden",  32'(peri_rden),  32'h0);
        check("wr_peri_wstrb", 32'(peri_wstrb), 32'h3);
        check("wr_peri_wdata", peri_wdata, 32'hCAFE_F00D);
        peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = 32'hFFFF_FFFF;
        step(); peri_gnt = 1'b0; peri_ready = 1'b0; peri_rdata = 32'h0;
        @(negedge clk);
        check("wr_resp_ready", 32'(resp_ready), 32'h2);
        check("wr_resp_rdata", resp_rdata, 32'h0);
        repeat (2) step();

        // Timeout: core 3 read accepted in cycle 1, ready never arrives.
        set_req(3, 1'b1, 1'b0, 32'h3000_0000, 32'h0, 4'h0);
        @(negedge clk);
        check("to_gnt", 32'(req_gnt), 32'h8);
        step(); clear_reqs(); peri_gnt = 1'b1;
        step(); peri_gnt = 1'b0;
        repeat (7) step();
        @(negedge clk);
        check("to_early_ready", 32'(resp_ready), 32'h0);
        step();
        @(negedge clk);
        check("to_resp_ready", 32'(resp_ready), 32'h8);
        check("to_resp_err",   32'(resp_err),   32'h8);
        check("to_resp_rdata", resp_rdata, 32'hDEAD_BEEF);
        step(); peri_ready = 1'b1; peri_rdata = 32'h5555_5555;
        step(); peri_ready = 1'b0;
        @(negedge clk);
        check("to_late_ready", 32'(resp_ready), 32'h0);
        check("to_rdata_hold", resp_rdata, 32'hDEAD_BEEF);
        repeat (2) step();

        // Reset while core 0's write sits in WAIT_RESP.
        set_req(0, 1'b0, 1'b1, 32'h5000_0020, 32'h1357_9BDF, 4'b1111);
        @(negedge clk);
        check("rs_gnt", 32'(req_gnt), 32'h1);
        step(); clear_reqs(); peri_gnt = 1'b1;
        step(); peri_gnt = 1'b0;
        step();
        rst_n = 1'b0;
        #1;
        check("rs_peri_wdata", peri_wdata, 32'h0);
        check("rs_peri_addr",  peri_addr,  32'h0);
        check("rs_peri_wstrb", 32'(peri_wstrb), 32'h0);
        check("rs_peri_wren",  32'(peri_wren),  32'h0);
        check("rs_resp_rdata", resp_rdata, 32'h0);
        step();
        rst_n = 1'b1;
        set_req(0, 1'b1, 1'b0, 32'h6000_0000, 32'h0, 4'h0);
        set_req(2, 1'b1, 1'b0, 32'h6000_0008, 32'h0, 4'h0);
        @(negedge clk);
        check("rs_after_gnt", 32'(req_gnt), 32'h1);
        step(); req_rden[0] = 1'b0;
        @(negedge clk);
        check("rs_after_addr", peri_addr, 32'h6000_0000);
        peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = 32'h0BAD_F00D;
        step(); peri_gnt = 1'b0; peri_ready = 1'b0;
        @(negedge clk);
        check("rs_after_resp", 32'(resp_ready), 32'h1);
        check("rs_next_gnt",   32'(req_gnt),    32'h4);
        step(); clear_reqs();
        peri_gnt = 1'b1; peri_ready = 1'b1; peri_rdata = 32'h2222_0000;
        step(); peri_gnt = 1'b0; peri_ready = 1'b0;
        repeat (3) step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/peri_bus_arbiter.md
# peri_bus_arbiter

Shares the single peripheral access port among all `NUM_PE` NanoCore instances, so every core, not only PE 0, can reach memory-mapped peripherals. The block sits between the per-core peripheral request ports and the top-level `o_peri_*`/`i_peri_*` bus. It performs round-robin arbitration and allows one outstanding transaction at a time. It routes each response back to its owner and recovers from a silent peripheral with a timeout.

## Interface
- `NUM_PE`, 4: number of requesting cores.
- `TIMEOUT`, 1024: maximum cycles spent waiting for `i_peri_ready` after downstream grant; 0 disables the timeout.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_req_rden`  in  NUM_PE  per-core read request, held until granted.
- `i_req_wren`  in  NUM_PE  per-core write request, held until granted.
- `i_req_addr`  in  NUM_PE*32  per-core address; slice `[k*32+:32]`.
- `i_req_wdata`  in  NUM_PE*32  per-core write data.
- `i_req_wstrb`  in  NUM_PE*4  per-core byte strobes.
- `o_req_gnt`  out  NUM_PE  one-hot acceptance of a request.
- `o_resp_ready`  out  NUM_PE  one-hot response pulse to the owner.
- `o_resp_err`  out  NUM_PE  one-hot timeout flag, coincident with `o_resp_ready`.
- `o_resp_rdata`  out  32  response data, shared by all cores.
- `o_peri_rden`, `o_peri_wren`  out  1  downstream request.
- `o_peri_addr`, `o_peri_wdata`  out  32  downstream payload.
- `o_peri_wstrb`  out  4  downstream strobes.
- `i_peri_rdata`  in  32  downstream read data.
- `i_peri_ready`  in  1  downstream response, one per transaction, for reads and writes.
- `i_peri_gnt`  in  1  downstream acceptance.

## Operation
- Request from core k is `rden[k] | wren[k]`. If both are set, the request is a write and `rden` is ignored.
- States: IDLE, ISSUE, WAIT_RESP.
- **IDLE**
  - If any request is pending, the round-robin winner w is chosen, starting the search at `rr_ptr`.
  - `o_req_gnt[w]` is driven combinationally in the same cycle.
  - Payload, op and owner w are latched; `rr_ptr` becomes `(w+1) mod NUM_PE`.
  - Next state is ISSUE.
- **ISSUE**
  - Drives `o_peri_*` from the latched registers. `o_peri_wstrb` is forced to 0 for reads.
  - On `i_peri_gnt` with `i_peri_ready` in the same cycle, the transaction completes and the next state is IDLE.
  - On `i_peri_gnt` alone, the next state is WAIT_RESP and the timeout counter clears.
  - `i_peri_ready` without `i_peri_gnt` is ignored.
- **WAIT_RESP**
  - `o_peri_rden` and `o_peri_wren` are deasserted; payload outputs hold their last values.
  - On `i_peri_ready`, the transaction completes and the next state is IDLE.
  - Otherwise the counter increments. When it reaches `TIMEOUT` (and `TIMEOUT != 0`), the transaction completes with error and the next state is IDLE.
- **Completion**
  - Normal: `o_resp_ready[owner]` pulses, `o_resp_rdata = i_peri_rdata` for reads, 0 for writes.
  - Error: `o_resp_ready[owner]` and `o_resp_err[owner]` pulse, `o_resp_rdata = ERR_RDATA` (32'hDEAD_BEEF).
- `i_peri_ready` in IDLE is ignored, including after a timeout. A late response is dropped.
- The timeout counter width is `$clog2(TIMEOUT+1)` and it saturates; it never wraps.

## Timing
- Reset (asynchronous, any state): state IDLE, `rr_ptr` 0, counter 0, latched payload 0. All outputs are 0, and `o_req_gnt` is 0 because no request is pending at reset.
- Grant latency: 0 cycles. `o_req_gnt` is high in the same cycle as the request when in IDLE.
- Downstream request appears 1 cycle after the grant and holds until `i_peri_gnt`.
- `o_resp_ready`, `o_resp_err` and `o_resp_rdata` are registered and appear 1 cycle after `i_peri_ready` or the timeout cycle. They last 1 cycle; `o_resp_rdata` holds until the next response.
- The FSM is in IDLE during the response pulse cycle, so a new grant can be issued in that same cycle.
- Minimum spacing between back-to-back transactions: 2 cycles (grant, ISSUE with `gnt` and `ready` together).
- A requester deasserting before grant is legal; that request is simply not served.

## Structure
- Package `nanocore_peri_pkg`:
  - `peri_arb_state_e` enum (IDLE, ISSUE, WAIT_RESP).
  - `ERR_RDATA` constant.
  - `peri_req_t` struct (op, addr, wdata, wstrb).
- Sub-module `rr_arbiter #(N)`:
  - Inputs: request vector, pointer.
  - Outputs: one-hot grant and its index.
  - Masked/unmasked priority-encode, purely combinational.
- Top module holds the FSM, payload registers, timeout counter and response demux.

## Test plan
- **Single read:** core 2 read at 0x1000_0004; peripheral returns `gnt` in cycle 2 and `ready` in cycle 4 with 0x1234_5678. Required: `o_req_gnt[2]` in cycle 0; `o_resp_ready[2]` in cycle 5 with rdata 0x1234_5678.
- **Round-robin fairness:** all 4 cores request continuously with `gnt` and `ready` returned together. Required: grant order 0,1,2,3,0; a new grant every 2 cycles.
- **Write with both enables:** core 1 drives `rden=wren=1`, wstrb 4'b0011. Required: `o_peri_wren=1`, `o_peri_rden=0`, wstrb 4'b0011; response rdata 0.
- **Timeout:** `TIMEOUT`=8; `gnt` given, `ready` never arrives. Required: `o_resp_ready[k]` and `o_resp_err[k]` 9 cycles after `gnt` with 0xDEAD_BEEF. A later `i_peri_ready` produces no response.
- **Reset during WAIT_RESP:** assert `i_rst_n`=0 mid-wait. Required: all outputs 0 immediately; after release, the next requester wins starting from core 0.
